// File: rtl/mult_seq_ctrl_if.sv
// Operand/result and shared-adder bundle between the execute stage and the
// shift-add multiplier controller.
//   master : execute stage side (issues requests, owns the shared adder)
//   slave  : mult_seq_ctrl
interface mult_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, op_a, op_b, add_sum,
    input  add_a, add_b, busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, op_a, op_b, add_sum,
    output add_a, add_b, busy, done, hi, lo
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Multi-cycle shift-add multiplier controller for MULT/MULTU.
// Borrows the execute-stage ripple adder through add_a/add_b/add_sum; one
// add and one multiplier bit per cycle, 64-bit product delivered on hi/lo.
// Optional macro MULT_SIGNED_EN: adds the ABS_A/ABS_B/NEG_LO/NEG_HI states
// for signed MULT. Without it every operation is unsigned and is_signed is
// ignored.
// Latency (start-sampling edge = cycle 0): unsigned done in WIDTH+1,
// signed done in WIDTH+5.
module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mult_seq_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MUL    = 3'd1,
    S_DONE   = 3'd2
`ifdef MULT_SIGNED_EN
    ,
    S_ABS_A  = 3'd3,
    S_ABS_B  = 3'd4,
    S_NEG_LO = 3'd5,
    S_NEG_HI = 3'd6
`endif
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_p_hi;
  logic [WIDTH-1:0] r_p_lo;
  logic [WIDTH-1:0] r_mcand;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0] w_p_hi_nxt;
  logic [WIDTH-1:0] w_p_lo_nxt;
  logic [WIDTH-1:0] w_mcand_nxt;
  logic [CNT_W-1:0] w_count_nxt;

  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic             w_carry;

`ifdef MULT_SIGNED_EN
  logic             r_sign;       // result must be negated
  logic             r_sgn;        // operation is signed MULT
  logic             r_neg_carry;  // carry from NEG_LO into NEG_HI
  logic             w_sign_nxt;
  logic             w_sgn_nxt;
  logic             w_neg_carry_nxt;
`else
  logic             w_unused_is_signed;
  assign w_unused_is_signed = bus.is_signed;
`endif

  // Adder operand selection; depends only on state and registers so the
  // external adder path never loops back through this block.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the case leaves it unassigned (no inferred latch).
    w_add_a = '0;
    w_add_b = '0;
    case (r_state)
      S_MUL: begin
        w_add_a = r_p_hi;
        w_add_b = r_p_lo[0] ? r_mcand : '0;
      end
`ifdef MULT_SIGNED_EN
      S_ABS_A: begin
        w_add_a = ~r_mcand;
        w_add_b = WIDTH'(1);
      end
      S_ABS_B: begin
        w_add_a = ~r_p_lo;
        w_add_b = WIDTH'(1);
      end
      S_NEG_LO: begin
        w_add_a = ~r_p_lo;
        w_add_b = WIDTH'(1);
      end
      S_NEG_HI: begin
        w_add_a = ~r_p_hi;
        w_add_b = {{(WIDTH-1){1'b0}}, r_neg_carry};
      end
`endif
      default: ;
    endcase
  end

  // Carry out of the shared adder, rebuilt from the operand and sum MSBs
  // because the adder only exposes its sum.
  assign w_carry = (w_add_a[WIDTH-1] & w_add_b[WIDTH-1])
                 | ((w_add_a[WIDTH-1] | w_add_b[WIDTH-1]) & ~bus.add_sum[WIDTH-1]);

  // Next state and next datapath values.
  always_comb begin
    w_state_nxt     = r_state;
    w_p_hi_nxt      = r_p_hi;
    w_p_lo_nxt      = r_p_lo;
    w_mcand_nxt     = r_mcand;
    w_count_nxt     = r_count;
`ifdef MULT_SIGNED_EN
    w_sign_nxt      = r_sign;
    w_sgn_nxt       = r_sgn;
    w_neg_carry_nxt = r_neg_carry;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_mcand_nxt = bus.op_a;
          w_p_lo_nxt  = bus.op_b;
          w_p_hi_nxt  = '0;
          w_count_nxt = '0;
`ifdef MULT_SIGNED_EN
          w_sign_nxt  = bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
          w_sgn_nxt   = bus.is_signed;
          w_state_nxt = bus.is_signed ? S_ABS_A : S_MUL;
`else
          w_state_nxt = S_MUL;
`endif
        end
      end
`ifdef MULT_SIGNED_EN
      // Both ABS steps always take their cycle so signed latency is fixed.
      S_ABS_A: begin
        if (r_mcand[WIDTH-1]) w_mcand_nxt = bus.add_sum;
        w_state_nxt = S_ABS_B;
      end
      S_ABS_B: begin
        if (r_p_lo[WIDTH-1]) w_p_lo_nxt = bus.add_sum;
        w_state_nxt = S_MUL;
      end
`endif
      S_MUL: begin
        w_p_hi_nxt  = {w_carry, bus.add_sum[WIDTH-1:1]};
        w_p_lo_nxt  = {bus.add_sum[0], r_p_lo[WIDTH-1:1]};
        w_count_nxt = r_count + 1'b1;
        if (r_count == CNT_W'(WIDTH-1)) begin
`ifdef MULT_SIGNED_EN
          w_state_nxt = r_sgn ? S_NEG_LO : S_DONE;
`else
          w_state_nxt = S_DONE;
`endif
        end
      end
`ifdef MULT_SIGNED_EN
      // Negation cycles run for every signed op; they only write the
      // product when the result sign is negative.
      S_NEG_LO: begin
        if (r_sign) begin
          w_p_lo_nxt      = bus.add_sum;
          w_neg_carry_nxt = w_carry;
        end
        w_state_nxt = S_NEG_HI;
      end
      S_NEG_HI: begin
        if (r_sign) w_p_hi_nxt = bus.add_sum;
        w_state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Datapath registers; hi/lo load on entry to DONE so they are valid in
  // the done cycle and hold untouched until the next DONE.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: every register here is control-visible and small, so all of it
    // is reset; nothing here is a memory array that would be left unreset.
    if (reset) begin
      r_p_hi      <= '0;
      r_p_lo      <= '0;
      r_mcand     <= '0;
      r_count     <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
`ifdef MULT_SIGNED_EN
      r_sign      <= 1'b0;
      r_sgn       <= 1'b0;
      r_neg_carry <= 1'b0;
`endif
    end else begin
      r_p_hi      <= w_p_hi_nxt;
      r_p_lo      <= w_p_lo_nxt;
      r_mcand     <= w_mcand_nxt;
      r_count     <= w_count_nxt;
`ifdef MULT_SIGNED_EN
      r_sign      <= w_sign_nxt;
      r_sgn       <= w_sgn_nxt;
      r_neg_carry <= w_neg_carry_nxt;
`endif
      if (w_state_nxt == S_DONE) begin
        r_hi <= w_p_hi_nxt;
        r_lo <= w_p_lo_nxt;
      end
    end
  end

  assign bus.add_a = w_add_a;
  assign bus.add_b = w_add_b;
  assign bus.busy  = (r_state != S_IDLE);
  assign bus.done  = (r_state == S_DONE);
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: table of operand/expected-product
// records plus hand-written handshake and mid-operation reset sequences.
// Expected values follow MULT_SIGNED_EN when it is defined for the build.
module tb_mult_seq_ctrl;

  localparam int W = 32;
`ifdef MULT_SIGNED_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif
  localparam int LU = W + 1;                 // unsigned latency
  localparam int LS = SE ? (W + 5) : (W + 1); // signed-request latency

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_seq_ctrl_if #(.WIDTH(W)) bus ();

  // Shared execute-stage adder (environment, not part of the controller).
  assign bus.add_sum = bus.add_a + bus.add_b;

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation (accepted at edge 0) and watch it for 45 cycles.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int exp_lat, input logic [31:0] prev_hi,
                        input logic [31:0] prev_lo, input string tag);
    int lat;
    int ndone;
    bit busy_bad;
    bit hold_bad;
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = s; bus.op_a = a; bus.op_b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.op_a = '0; bus.op_b = '0;
    lat = 0; ndone = 0; busy_bad = 1'b0; hold_bad = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        if (lat == 0) lat = k;
      end
      if (bus.busy !== (k <= exp_lat)) busy_bad = 1'b1;
      if (k < exp_lat && (bus.hi !== prev_hi || bus.lo !== prev_lo)) hold_bad = 1'b1;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_ndone"}, 64'(ndone), 64'd1);
    check({tag, "_busy_window"}, 64'(busy_bad), 64'd0);
    check({tag, "_hilo_hold"}, 64'(hold_bad), 64'd0);
    check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
  endtask

  initial begin
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    int          nd;
    int          lat1;
    int          lat2;
    logic [31:0] lo1;
    logic [31:0] lo2;
    logic        busy34;
    logic        busy35;

    // {signed, a, b, hi, lo, latency}
    tbl[0] = '{1'b0, 32'd3,         32'd5,         32'h0000_0000, 32'h0000_000F, LU};
    tbl[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LU};
    tbl[2] = '{1'b1, 32'hFFFF_FFFD, 32'd5,
               SE ? 32'hFFFF_FFFF : 32'h0000_0004, 32'hFFFF_FFF1, LS};
    tbl[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, LS};
    tbl[4] = '{1'b1, 32'd7,         32'd6,         32'h0000_0000, 32'h0000_002A, LS};
    tbl[5] = '{1'b0, 32'd0,         32'h1234_5678, 32'h0000_0000, 32'h0000_0000, LU};
    tbl[6] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               SE ? 32'h0000_0000 : 32'hFFFF_FFFE, 32'h0000_0001, LS};
    tbl[7] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000,
               SE ? 32'hC000_0000 : 32'h3FFF_FFFF, 32'h8000_0000, LS};
    tbl[8] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, LU};
    tbl[9] = '{1'b1, 32'd1,         32'hFFFF_FFFF,
               SE ? 32'hFFFF_FFFF : 32'h0000_0000, 32'hFFFF_FFFF, LS};

    // Reset state.
    reset = 1'b1;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.op_a = '0; bus.op_b = '0;
    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_hi", 64'(bus.hi), 64'd0);
    check("reset_lo", 64'(bus.lo), 64'd0);
    check("idle_add_a", 64'(bus.add_a), 64'd0);
    check("idle_add_b", 64'(bus.add_b), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Table-driven operations.
    prev_hi = '0;
    prev_lo = '0;
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].exp_hi, tbl[i].exp_lo,
             tbl[i].exp_lat, prev_hi, prev_lo, $sformatf("vec%0d", i));
      prev_hi = tbl[i].exp_hi;
      prev_lo = tbl[i].exp_lo;
    end

    // Handshake: 3x5 accepted at edge 0; 9x9 starts at cycle 5 (busy) and
    // cycle 33 (DONE) are ignored; 2x3 at cycle 34 is accepted.
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.op_a = 32'd3; bus.op_b = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    nd = 0; lat1 = 0; lat2 = 0; lo1 = '0; lo2 = '0; busy34 = 1'bx; busy35 = 1'bx;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        nd++;
        if (nd == 1) begin lat1 = k; lo1 = bus.lo; end
        else if (nd == 2) begin lat2 = k; lo2 = bus.lo; end
      end
      if (k == 34) busy34 = bus.busy;
      if (k == 35) busy35 = bus.busy;
      bus.start     = (k == 5) || (k == 33) || (k == 34);
      bus.is_signed = 1'b0;
      bus.op_a      = (k == 34) ? 32'd2 : 32'd9;
      bus.op_b      = (k == 34) ? 32'd3 : 32'd9;
    end
    bus.start = 1'b0;
    check("hs_ndone", 64'(nd), 64'd2);
    check("hs_first_latency", 64'(lat1), 64'(LU));
    check("hs_first_lo", 64'(lo1), 64'd15);
    check("hs_idle_after_done", 64'(busy34), 64'd0);
    check("hs_accept_after_done", 64'(busy35), 64'd1);
    check("hs_second_latency", 64'(lat2), 64'(34 + LU));
    check("hs_second_lo", 64'(lo2), 64'd6);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.op_a = 32'd3; bus.op_b = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("rst_pre_busy", 64'(bus.busy), 64'd1);
    check("rst_pre_lo", 64'(bus.lo), 64'd6);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_done", 64'(bus.done), 64'd0);
    check("rst_mid_hi", 64'(bus.hi), 64'd0);
    check("rst_mid_lo", 64'(bus.lo), 64'd0);
    check("rst_mid_add_a", 64'(bus.add_a), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(1'b0, 32'd2, 32'd2, 32'd0, 32'd4, LU, 32'd0, 32'd0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
